// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - soft-reset request in, sequenced resets and done out
interface reset_sequencer_if #(
  parameter int NUM_OUTPUTS = 4
) ();
  logic                   soft_reset_req;
  logic [NUM_OUTPUTS-1:0] reset_n;
  logic                   done;

  modport master (input soft_reset_req, output reset_n, output done);
  modport slave  (output soft_reset_req, input reset_n, input done);
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - synchronised, held and ordered release of active-low resets
module reset_sequencer #(
  parameter int SYNC_STAGES = 3,
  parameter int MIN_HOLD    = 64,
  parameter int RELEASE_GAP = 16,
  parameter int NUM_OUTPUTS = 4
) (
  input  logic              clock,
  input  logic              ext_reset_n,
  input  logic              lock,
  reset_sequencer_if.master bus
);
  localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int IDX_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);

  typedef enum logic [1:0] {S_RESET, S_HOLD, S_RELEASE, S_RUN} state_t;

  logic                   async_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_ok;
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] reset_n_q, reset_n_d;
  logic                   done_q, done_d;

  // Lock loss counts as reset so downstream logic never runs on an unstable clock.
  assign async_n = ext_reset_n & lock;
  assign sync_ok = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge async_n) begin
    if (!async_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge async_n) begin
    if (!async_n) begin
      state_q    <= S_RESET;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
      reset_n_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
      reset_n_q  <= reset_n_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    reset_n_d  = reset_n_q;
    done_d     = done_q;
    case (state_q)
      S_RESET: begin
        if (sync_ok) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d   = '0;
          reset_n_d    = '0;
          reset_n_d[0] = 1'b1;
          idx_d        = '0;
          gap_cnt_d    = '0;
          if (NUM_OUTPUTS == 1) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        gap_cnt_d = gap_cnt_q + GAP_W'(1);
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          idx_d     = idx_q + IDX_W'(1);
          for (int i = 1; i < NUM_OUTPUTS; i++) begin
            if (i == int'(idx_q) + 1) reset_n_d[i] = 1'b1;
          end
          if (int'(idx_q) + 2 == NUM_OUTPUTS) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
      end
      default: state_d = S_RESET;
    endcase
    // Soft restart skips the synchroniser: the clock is already known good here.
    if (bus.soft_reset_req && state_q != S_RESET) begin
      state_d    = S_HOLD;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = '0;
      reset_n_d  = '0;
      done_d     = 1'b0;
    end
  end

  assign bus.reset_n = reset_n_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed checks of default and minimal-parameter sequencers
module tb_reset_sequencer;
  logic clock;
  logic ext_reset_n;
  logic lock;
  logic soft_reset_req;
  int   cur;
  int   vectors;
  int   miscompares;

  reset_sequencer_if #(.NUM_OUTPUTS(4)) bus0 ();
  reset_sequencer_if #(.NUM_OUTPUTS(1)) bus1 ();
  reset_sequencer_if #(.NUM_OUTPUTS(3)) bus2 ();

  assign bus0.soft_reset_req = soft_reset_req;
  assign bus1.soft_reset_req = soft_reset_req;
  assign bus2.soft_reset_req = soft_reset_req;

  reset_sequencer dut_def (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .lock        (lock),
    .bus         (bus0)
  );

  reset_sequencer #(.SYNC_STAGES(2), .MIN_HOLD(1), .RELEASE_GAP(1), .NUM_OUTPUTS(1)) dut_min1 (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .lock        (lock),
    .bus         (bus1)
  );

  reset_sequencer #(.SYNC_STAGES(2), .MIN_HOLD(1), .RELEASE_GAP(1), .NUM_OUTPUTS(3)) dut_min3 (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .lock        (lock),
    .bus         (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to edge k (counted from the last async_n rise) and sample 1 ns later.
  task automatic goto_edge(input int k);
    while (cur < k) begin
      @(posedge clock);
      cur++;
    end
    #1;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    cur            = 0;
    ext_reset_n    = 1'b1;
    lock           = 1'b0;
    soft_reset_req = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_def_reset_n", 32'(bus0.reset_n), 32'h0);
    check("rst_def_done",    32'(bus0.done),    32'h0);
    check("rst_min1_reset_n", 32'(bus1.reset_n), 32'h0);
    check("rst_min3_reset_n", 32'(bus2.reset_n), 32'h0);

    #4;
    lock = 1'b1;
    cur  = 0;
    goto_edge(3);
    check("min1_e3_reset_n", 32'(bus1.reset_n), 32'h0);
    check("min1_e3_done",    32'(bus1.done),    32'h0);
    check("min3_e3_reset_n", 32'(bus2.reset_n), 32'h0);
    goto_edge(4);
    check("min1_e4_reset_n", 32'(bus1.reset_n), 32'h1);
    check("min1_e4_done",    32'(bus1.done),    32'h1);
    check("min3_e4_reset_n", 32'(bus2.reset_n), 32'h1);
    check("min3_e4_done",    32'(bus2.done),    32'h0);
    goto_edge(5);
    check("min3_e5_reset_n", 32'(bus2.reset_n), 32'h3);
    goto_edge(6);
    check("min3_e6_reset_n", 32'(bus2.reset_n), 32'h7);
    check("min3_e6_done",    32'(bus2.done),    32'h1);

    goto_edge(67);
    check("def_e67", 32'(bus0.reset_n), 32'h0);
    goto_edge(68);
    check("def_e68", 32'(bus0.reset_n), 32'h1);
    goto_edge(83);
    check("def_e83", 32'(bus0.reset_n), 32'h1);
    goto_edge(84);
    check("def_e84", 32'(bus0.reset_n), 32'h3);
    goto_edge(99);
    check("def_e99", 32'(bus0.reset_n), 32'h3);
    goto_edge(100);
    check("def_e100", 32'(bus0.reset_n), 32'h7);
    goto_edge(115);
    check("def_e115_reset_n", 32'(bus0.reset_n), 32'h7);
    check("def_e115_done",    32'(bus0.done),    32'h0);
    goto_edge(116);
    check("def_e116_reset_n", 32'(bus0.reset_n), 32'hF);
    check("def_e116_done",    32'(bus0.done),    32'h1);

    goto_edge(120);
    #3;
    lock = 1'b0;
    #1;
    check("lock_drop_reset_n", 32'(bus0.reset_n), 32'h0);
    check("lock_drop_done",    32'(bus0.done),    32'h0);
    #2;
    lock = 1'b1;
    cur  = 0;
    goto_edge(67);
    check("relock_e67", 32'(bus0.reset_n), 32'h0);
    goto_edge(68);
    check("relock_e68", 32'(bus0.reset_n), 32'h1);
    goto_edge(116);
    check("relock_e116_reset_n", 32'(bus0.reset_n), 32'hF);
    check("relock_e116_done",    32'(bus0.done),    32'h1);

    goto_edge(120);
    soft_reset_req = 1'b1;
    goto_edge(121);
    check("soft1_E_reset_n", 32'(bus0.reset_n), 32'h0);
    check("soft1_E_done",    32'(bus0.done),    32'h0);
    soft_reset_req = 1'b0;
    goto_edge(184);
    check("soft1_E63", 32'(bus0.reset_n), 32'h0);
    goto_edge(185);
    check("soft1_E64", 32'(bus0.reset_n), 32'h1);
    goto_edge(232);
    check("soft1_E111_reset_n", 32'(bus0.reset_n), 32'h7);
    check("soft1_E111_done",    32'(bus0.done),    32'h0);
    goto_edge(233);
    check("soft1_E112_reset_n", 32'(bus0.reset_n), 32'hF);
    check("soft1_E112_done",    32'(bus0.done),    32'h1);

    #4;
    ext_reset_n = 1'b0;
    #1;
    check("ext_drop_run", 32'(bus0.reset_n), 32'h0);
    ext_reset_n = 1'b1;
    cur = 0;
    goto_edge(90);
    check("mid_release_0x3", 32'(bus0.reset_n), 32'h3);
    #3;
    ext_reset_n = 1'b0;
    #1;
    check("ext_drop_release_reset_n", 32'(bus0.reset_n), 32'h0);
    check("ext_drop_release_done",    32'(bus0.done),    32'h0);
    #1;
    ext_reset_n = 1'b1;
    cur = 0;
    goto_edge(67);
    check("ext_restart_e67", 32'(bus0.reset_n), 32'h0);
    goto_edge(68);
    check("ext_restart_e68", 32'(bus0.reset_n), 32'h1);

    goto_edge(116);
    check("ext_restart_e116", 32'(bus0.reset_n), 32'hF);
    soft_reset_req = 1'b1;
    goto_edge(117);
    check("soft10_E", 32'(bus0.reset_n), 32'h0);
    goto_edge(126);
    check("soft10_E9", 32'(bus0.reset_n), 32'h0);
    soft_reset_req = 1'b0;
    goto_edge(189);
    check("soft10_E9_63", 32'(bus0.reset_n), 32'h0);
    goto_edge(190);
    check("soft10_E9_64", 32'(bus0.reset_n), 32'h1);
    goto_edge(238);
    check("soft10_E9_112_reset_n", 32'(bus0.reset_n), 32'hF);
    check("soft10_E9_112_done",    32'(bus0.done),    32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset generator that synchronises deassertion of a combined external-reset/PLL-lock condition and holds reset for a minimum time. It then releases NUM_OUTPUTS active-low reset lines in a fixed order, spaced RELEASE_GAP cycles apart. It also accepts a synchronous soft-reset request that re-runs the hold/release sequence without passing through the synchroniser. It sits at the top of the video controller, fed by the pixel-clock PLL, and drives the resets of the timing generator, the framebuffer reader and the output stages in dependency order.

Parameters:
SYNC_STAGES, 3, depth of the deassertion synchroniser chain (legal: >= 2)
MIN_HOLD, 64, cycles reset is held after the synchroniser reports ready (legal: >= 1)
RELEASE_GAP, 16, cycles between successive output releases (legal: >= 1)
NUM_OUTPUTS, 4, number of sequenced reset outputs (legal: >= 1)

Ports:
clock  input  1  single system clock; all logic is on its rising edge
ext_reset_n  input  1  external reset, asynchronous, active-low
lock  input  1  PLL lock; low is treated as reset, asynchronously
soft_reset_req  input  1  synchronous to clock, active-high; restarts the sequence
reset_n  output  NUM_OUTPUTS  sequenced active-low resets; bit 0 is released first
done  output  1  high once all of reset_n is released

Behaviour:
- Internal async_n = ext_reset_n & lock. Reset is asynchronous and active-low; async_n is the only asynchronous reset of every flop.
- While async_n=0:
  - reset_n = all 0, done=0.
  - Synchroniser chain cleared, FSM=S_RESET, hold/gap counters and release index cleared.
  - Assertion of reset_n is immediate (combinational path through the flop resets); no clock is required.
- Edge numbering: edge k is the k-th rising clock edge after async_n rises.
- Synchroniser: chain of SYNC_STAGES flops shifting in 1. sync_ok (last stage) is 1 after edge SYNC_STAGES.
- FSM states: S_RESET, S_HOLD, S_RELEASE, S_RUN.
  - S_RESET: when sync_ok=1, go to S_HOLD with hold_cnt=0. This happens at edge SYNC_STAGES+1.
  - S_HOLD: hold_cnt increments each edge. On the edge where hold_cnt==MIN_HOLD-1, go to S_RELEASE, set reset_n[0]=1, idx=0, gap_cnt=0.
  - S_RELEASE:
    - gap_cnt increments each edge.
    - When gap_cnt==RELEASE_GAP-1: set idx=idx+1, reset_n[idx+1]=1, gap_cnt=0.
    - Go to S_RUN and set done=1 on the same edge the last bit is released.
    - If NUM_OUTPUTS=1, go directly from S_HOLD to S_RUN with done=1 on the reset_n[0] release edge.
  - S_RUN: steady state; reset_n all 1, done=1.
- Timing formula: reset_n[i] rises at edge SYNC_STAGES+1+MIN_HOLD+i*RELEASE_GAP; done rises with reset_n[NUM_OUTPUTS-1].
  - Defaults: reset_n[0..3] rise at edges 68, 84, 100, 116; done rises at edge 116.
- Release order is monotonic: reset_n[j]=1 implies reset_n[i]=1 for all i<j. reset_n is never partially re-asserted.
- soft_reset_req:
  - Sampled only in S_HOLD, S_RELEASE and S_RUN; ignored in S_RESET.
  - When sampled 1 at edge E: reset_n=all 0, done=0, FSM=S_HOLD, hold_cnt=0, idx and gap_cnt cleared, synchroniser untouched.
  - While soft_reset_req is held high, hold_cnt stays 0.
  - After it drops, reset_n[0] rises at edge F+MIN_HOLD, where F is the last edge that sampled soft_reset_req=1.
- Async reset mid-operation: a lock or ext_reset_n drop in any state, including mid-release, immediately forces the full reset state above. The sequence restarts from the synchroniser when async_n returns.
- Counter widths: hold_cnt is clog2(MIN_HOLD) bits, min 1; gap_cnt is clog2(RELEASE_GAP) bits, min 1; idx is clog2(NUM_OUTPUTS) bits, min 1. No wrap in normal operation.
- All outputs are registered; no combinational path from soft_reset_req to outputs.

Test Plan:
- Defaults; ext_reset_n=1, lock 0->1 -> reset_n rises bitwise at edges 68/84/100/116 (0x1,0x3,0x7,0xF); done=1 at edge 116 and not before.
- In S_RUN, lock pulses low for 3 ns between edges -> reset_n=0x0 and done=0 without a clock edge; the full sequence repeats, reset_n[0] again at edge 68.
- In S_RUN, soft_reset_req=1 for one cycle at edge E -> reset_n=0x0 at E; 0x1 at E+64, 0xF and done=1 at E+112.
- During S_RELEASE with reset_n=0x3, ext_reset_n pulled low -> reset_n=0x0 immediately; no bit rises before edge 68 of the next sequence.
- soft_reset_req held high for 10 cycles (edges E..E+9) -> reset_n stays 0x0; reset_n[0] rises at E+9+64.
- Parameter sweep SYNC_STAGES=2, MIN_HOLD=1, RELEASE_GAP=1, NUM_OUTPUTS=1 -> reset_n[0] and done rise together at edge 4; also check NUM_OUTPUTS=3, RELEASE_GAP=1 -> consecutive-edge releases.
